// File: rtl/bigadd_sched_pkg.sv
// Shared constants, ID-width helper and pipeline-stage type for the bigadd_sched adder scheduler.
package bigadd_sched_pkg;

  localparam int W        = 64;
  localparam int HALF     = 32;
  localparam int ID_MAX_W = 3;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // id is sized for the largest supported NREQ; narrower configs ignore the top bits
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [W-1:0]        a;
    logic [W-1:0]        b;
  } stage_t;

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant: first eligible requester after `last`, searching upward modulo NREQ.
// Latency: combinational. Backpressure: none, the grant follows the eligible mask directly.
module rr_grant
  import bigadd_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = id_w(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  // Walk the search order backwards so the nearest eligible requester is written last and wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (elig[IW'(idx)]) begin
        gnt              = '0;
        gnt[IW'(idx)]    = 1'b1;
        gnt_idx          = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/bigadd_sched.sv
// Round-robin scheduler sharing one pipelined 64-bit adder; result 1+LAT cycles after accept, one add per cycle.
// No back-pressure: o_valid is a one-cycle strobe. BIGADD_SCHED_ACCUM_EN adds interlocked per-requester accumulators.
module bigadd_sched
  import bigadd_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int LAT  = 2,
  localparam int IW   = id_w(NREQ)
) (
  input  logic              i_clk,
  input  logic              i_areset_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_a,
  input  logic [NREQ*W-1:0] i_b,
`ifdef BIGADD_SCHED_ACCUM_EN
  input  logic [NREQ-1:0]   i_acc,
  input  logic [NREQ-1:0]   i_clr,
  output logic [NREQ*W-1:0] o_acc,
`endif
  output logic [NREQ-1:0]   o_ack,
  output logic              o_valid,
  output logic [IW-1:0]     o_id,
  output logic [W-1:0]      o_r,
  output logic              o_busy
);

  logic [IW-1:0]       last;
  logic [IW-1:0]       gnt_idx;
  logic [NREQ-1:0]     elig;
  logic [NREQ-1:0]     gnt;
  logic [W-1:0]        opa;
  stage_t              s0;
  logic                res_vld;
  logic [ID_MAX_W-1:0] res_id;
  logic [W-1:0]        res_r;
  logic                busy;
  logic                unused_id;

`ifdef BIGADD_SCHED_ACCUM_EN
  logic [NREQ-1:0][W-1:0] acc;
  logic [NREQ-1:0]        inflight;
  logic [LAT:0]           acc_pipe;
  logic                   ret_acc;

  // A requester with an accumulate in flight is skipped until its result has been written back.
  assign elig    = i_req & ~inflight;
  assign opa     = i_acc[gnt_idx] ? acc[gnt_idx] : i_a[W*int'(gnt_idx) +: W];
  assign o_acc   = acc;
  assign ret_acc = res_vld & acc_pipe[LAT];

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      acc      <= '0;
      inflight <= '0;
      acc_pipe <= '0;
    end else begin
      acc_pipe[0] <= |(gnt & i_acc);
      for (int i = 1; i <= LAT; i++) acc_pipe[i] <= acc_pipe[i-1];
      for (int j = 0; j < NREQ; j++) begin
        if (ret_acc && res_id == ID_MAX_W'(j)) begin
          acc[j]      <= res_r;
          inflight[j] <= 1'b0;
        end else begin
          if (i_clr[j]) acc[j] <= '0;
          if (gnt[j] && i_acc[j]) inflight[j] <= 1'b1;
        end
      end
    end
  end
`else
  assign elig = i_req;
  assign opa  = i_a[W*int'(gnt_idx) +: W];
`endif

  rr_grant #(.NREQ(NREQ)) u_rr_grant (
    .elig    (elig),
    .last    (last),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign o_ack = gnt;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      last <= IW'(NREQ-1);
      s0   <= '0;
    end else begin
      s0.valid <= |gnt;
      if (|gnt) begin
        last <= gnt_idx;
        s0.id <= ID_MAX_W'(gnt_idx);
        s0.a  <= opa;
        s0.b  <= i_b[W*int'(gnt_idx) +: W];
      end
    end
  end

  generate
    if (LAT == 0) begin : g_lat0
      assign res_vld = s0.valid;
      assign res_id  = s0.id;
      assign res_r   = s0.a + s0.b;
      assign busy    = s0.valid;
    end else if (LAT == 1) begin : g_lat1
      logic                v1;
      logic [ID_MAX_W-1:0] id1;
      logic [W-1:0]        r1;
      always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
          v1  <= 1'b0;
          id1 <= '0;
          r1  <= '0;
        end else begin
          v1 <= s0.valid;
          if (s0.valid) begin
            id1 <= s0.id;
            r1  <= s0.a + s0.b;
          end
        end
      end
      assign res_vld = v1;
      assign res_id  = id1;
      assign res_r   = r1;
      assign busy    = s0.valid | v1;
    end else begin : g_lat2
      logic                v1, v2, c1;
      logic [ID_MAX_W-1:0] id1, id2;
      logic [HALF-1:0]     lo1, ah1, bh1;
      logic [W-1:0]        r2;
      // Low half and its carry settle in stage 1; the carry ripples into the high half in stage 2.
      always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
          v1  <= 1'b0;
          v2  <= 1'b0;
          c1  <= 1'b0;
          id1 <= '0;
          id2 <= '0;
          lo1 <= '0;
          ah1 <= '0;
          bh1 <= '0;
          r2  <= '0;
        end else begin
          v1 <= s0.valid;
          v2 <= v1;
          if (s0.valid) begin
            {c1, lo1} <= {1'b0, s0.a[HALF-1:0]} + {1'b0, s0.b[HALF-1:0]};
            ah1       <= s0.a[W-1:HALF];
            bh1       <= s0.b[W-1:HALF];
            id1       <= s0.id;
          end
          if (v1) begin
            r2  <= {ah1 + bh1 + HALF'(c1), lo1};
            id2 <= id1;
          end
        end
      end
      assign res_vld = v2;
      assign res_id  = id2;
      assign res_r   = r2;
      assign busy    = s0.valid | v1 | v2;
    end
  endgenerate

  assign o_valid   = res_vld;
  assign o_id      = res_id[IW-1:0];
  assign o_r       = res_r;
  assign o_busy    = busy;
  assign unused_id = ^res_id;

endmodule

// File: tb/tb_bigadd_sched.sv
// Bench for bigadd_sched (NREQ=4, LAT=2): random and directed requests against a queue-based model.
module tb_bigadd_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IW   = 2;

  logic                 i_clk = 1'b0;
  logic                 i_areset_n = 1'b0;
  logic [NREQ-1:0]      i_req = '0;
  logic [NREQ*64-1:0]   i_a = '0;
  logic [NREQ*64-1:0]   i_b = '0;
  logic [NREQ-1:0]      o_ack;
  logic                 o_valid;
  logic [IW-1:0]        o_id;
  logic [63:0]          o_r;
  logic                 o_busy;
`ifdef BIGADD_SCHED_ACCUM_EN
  logic [NREQ-1:0]      i_acc = '0;
  logic [NREQ-1:0]      i_clr = '0;
  logic [NREQ*64-1:0]   o_acc;
  bit                   clr_m [NREQ];
`endif

  always #5 i_clk = ~i_clk;

  bigadd_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_req      (i_req),
    .i_a        (i_a),
    .i_b        (i_b),
`ifdef BIGADD_SCHED_ACCUM_EN
    .i_acc      (i_acc),
    .i_clr      (i_clr),
    .o_acc      (o_acc),
`endif
    .o_ack      (o_ack),
    .o_valid    (o_valid),
    .o_id       (o_id),
    .o_r        (o_r),
    .o_busy     (o_busy)
  );

  typedef struct {
    int          due;
    int          id;
    logic [63:0] sum;
    bit          acc;
  } res_t;

  res_t        q[$];
  int          cyc;
  int          last_m;
  int          last_acc_cyc;
  int          n_tests;
  int          n_fail;
  bit          hold_mode;
  bit          req_m   [NREQ];
  bit          acc_req [NREQ];
  logic [63:0] a_m     [NREQ];
  logic [63:0] b_m     [NREQ];
  logic [63:0] acc_m   [NREQ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = 64'h0000_0000_FFFF_FFFF;
      2:       v = 64'(1);
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic drive();
    for (int j = 0; j < NREQ; j++) begin
      i_req[j]         = req_m[j];
      i_a[64*j +: 64]  = a_m[j];
      i_b[64*j +: 64]  = b_m[j];
`ifdef BIGADD_SCHED_ACCUM_EN
      i_acc[j]         = acc_req[j];
      i_clr[j]         = clr_m[j];
`endif
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit          elig [NREQ];
    int          g;
    int          idx;
    bit          ret;
    bit          exp_busy;
    logic [63:0] exp_ack;
    logic [63:0] opa;
    drive();
    @(negedge i_clk);
    for (int j = 0; j < NREQ; j++) elig[j] = req_m[j];
`ifdef BIGADD_SCHED_ACCUM_EN
    foreach (q[i]) if (q[i].acc) elig[q[i].id] = 1'b0;
`endif
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last_m + k) % NREQ;
      if (g < 0 && elig[idx]) g = idx;
    end
    exp_ack = (g >= 0) ? (64'(1) << g) : 64'(0);
    check("ack", 64'(o_ack), exp_ack);
    ret = (q.size() > 0) && (q[0].due == cyc);
    check("valid", 64'(o_valid), 64'(ret));
    if (ret) begin
      check("id", 64'(o_id), 64'(q[0].id));
      check("sum", o_r, q[0].sum);
    end
    exp_busy = (cyc - last_acc_cyc >= 1) && (cyc - last_acc_cyc <= LAT + 1);
    check("busy", 64'(o_busy), 64'(exp_busy));
`ifdef BIGADD_SCHED_ACCUM_EN
    for (int j = 0; j < NREQ; j++) check("acc", o_acc[64*j +: 64], acc_m[j]);
`endif
    @(posedge i_clk);
    opa = '0;
    if (g >= 0) opa = acc_req[g] ? acc_m[g] : a_m[g];
`ifdef BIGADD_SCHED_ACCUM_EN
    for (int j = 0; j < NREQ; j++) begin
      if (ret && q[0].acc && q[0].id == j) acc_m[j] = q[0].sum;
      else if (clr_m[j])                   acc_m[j] = '0;
    end
`endif
    if (ret) q.delete(0);
    if (g >= 0) begin
      q.push_back('{due: cyc + 1 + LAT, id: g, sum: opa + b_m[g], acc: acc_req[g]});
      last_m       = g;
      last_acc_cyc = cyc;
      if (!hold_mode) req_m[g] = 1'b0;
    end
    cyc++;
    #1;
  endtask

  function automatic bit any_req();
    bit r;
    r = 1'b0;
    for (int j = 0; j < NREQ; j++) r |= req_m[j];
    return r;
  endfunction

  task automatic drain();
    hold_mode = 1'b0;
    for (int t = 0; t < 40 && (any_req() || q.size() > 0); t++) step();
    step();
  endtask

  task automatic model_reset();
    q.delete();
    last_m       = NREQ - 1;
    last_acc_cyc = -100;
    for (int j = 0; j < NREQ; j++) begin
      req_m[j]   = 1'b0;
      acc_req[j] = 1'b0;
      acc_m[j]   = '0;
`ifdef BIGADD_SCHED_ACCUM_EN
      clr_m[j]   = 1'b0;
`endif
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    hold_mode = 1'b0;
    model_reset();
    for (int j = 0; j < NREQ; j++) begin
      a_m[j] = '0;
      b_m[j] = '0;
    end
    drive();

    // Reset state
    @(negedge i_clk);
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_busy",  64'(o_busy),  64'(0));
    check("rst_id",    64'(o_id),    64'(0));
    check("rst_r",     o_r,          64'(0));
    check("rst_ack",   64'(o_ack),   64'(0));
    @(posedge i_clk);
    #1 i_areset_n = 1'b1;

    // Single add, requester 1: 5 + 7
    req_m[1] = 1'b1; a_m[1] = 64'(5); b_m[1] = 64'(7);
    repeat (5) step();

    // All requesters continuously: A=j, B=100
    hold_mode = 1'b1;
    for (int j = 0; j < NREQ; j++) begin
      req_m[j] = 1'b1; a_m[j] = 64'(j); b_m[j] = 64'(100);
    end
    repeat (8) step();
    drain();

    // Carry across halves and 64-bit wrap
    req_m[0] = 1'b1; a_m[0] = 64'h0000_0000_FFFF_FFFF; b_m[0] = 64'(1);
    req_m[1] = 1'b1; a_m[1] = 64'hFFFF_FFFF_FFFF_FFFF; b_m[1] = 64'(1);
    drain();

    // One requester continuously is granted every cycle
    hold_mode = 1'b1;
    req_m[3] = 1'b1; a_m[3] = 64'h1234_5678_9ABC_DEF0; b_m[3] = 64'hFFFF_0000_0000_0001;
    repeat (5) step();
    drain();

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!req_m[j] && $urandom_range(0, 1) == 1) begin
          req_m[j] = 1'b1;
          a_m[j]   = rnd64();
          b_m[j]   = rnd64();
`ifdef BIGADD_SCHED_ACCUM_EN
          acc_req[j] = ($urandom_range(0, 2) == 0);
`endif
        end
`ifdef BIGADD_SCHED_ACCUM_EN
        clr_m[j] = ($urandom_range(0, 9) == 0);
`endif
      end
      step();
    end
`ifdef BIGADD_SCHED_ACCUM_EN
    for (int j = 0; j < NREQ; j++) clr_m[j] = 1'b0;
`endif
    drain();

    // Reset with three adds in flight
    hold_mode = 1'b1;
    for (int j = 0; j < NREQ; j++) begin
      req_m[j] = 1'b1; a_m[j] = rnd64(); b_m[j] = rnd64(); acc_req[j] = 1'b0;
    end
    repeat (3) step();
    hold_mode = 1'b0;
    model_reset();
    drive();
    i_areset_n = 1'b0;
    @(negedge i_clk);
    check("mid_rst_valid", 64'(o_valid), 64'(0));
    check("mid_rst_busy",  64'(o_busy),  64'(0));
    check("mid_rst_r",     o_r,          64'(0));
    @(posedge i_clk);
    #1 i_areset_n = 1'b1;
    cyc++;
    repeat (5) step();
    for (int j = 0; j < NREQ; j++) begin
      req_m[j] = 1'b1; a_m[j] = 64'(j + 1); b_m[j] = 64'(j * 3);
    end
    drive();
    #1 check("post_rst_grant", 64'(o_ack), 64'(1));
    drain();

`ifdef BIGADD_SCHED_ACCUM_EN
    // Requester 2 accumulates B=10 alongside plain traffic from requester 0; clear pulses on retire edges
    for (int j = 0; j < NREQ; j++) clr_m[j] = 1'b1;
    step();
    for (int j = 0; j < NREQ; j++) clr_m[j] = 1'b0;
    hold_mode = 1'b1;
    req_m[2] = 1'b1; acc_req[2] = 1'b1; a_m[2] = rnd64(); b_m[2] = 64'(10);
    req_m[0] = 1'b1; acc_req[0] = 1'b0; a_m[0] = rnd64(); b_m[0] = rnd64();
    for (int t = 0; t < 12; t++) begin
      clr_m[2] = (q.size() > 0) && (q[0].due == cyc) && (q[0].id == 2) && q[0].acc;
      step();
    end
    clr_m[2] = 1'b0;
    req_m[2] = 1'b0;
    drain();
    check("acc2_after_3", o_acc[128 +: 64], 64'(30));
    clr_m[2] = 1'b1;
    step();
    clr_m[2] = 1'b0;
    step();
    check("acc2_cleared", o_acc[128 +: 64], 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
